// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the control FSM and the unified data-memory port.
// Define MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of performing them.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mdr_out,
  output logic [2:0]  dec_sel,
  output logic [31:0] dec_addr,
  output logic        done,
  output logic        err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   mdr_q, mdr_d;
  logic [2:0]    dec_sel_q, dec_sel_d;
  logic [31:0]   dec_addr_q, dec_addr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          f3_ok;
  logic          legal;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic [2:0]    sel_n;

  // Request legality: stores only allow B/H/W, loads additionally BU/HU.
  always_comb begin
    if (req_write) f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else           f3_ok = !((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
`ifdef MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   legal = f3_ok && !req_addr[0];
      2'b10:   legal = f3_ok && (req_addr[1:0] == 2'b00);
      default: legal = f3_ok;
    endcase
`else
    legal = f3_ok;
`endif
  end

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = req_wdata;
    if (req_write) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_n    = 4'b0001 << req_addr[1:0];
          wdata_n = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_n    = 4'b0011 << {req_addr[1], 1'b0};
          wdata_n = {2{req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (req_funct3)
      3'b000:  sel_n = 3'd0;
      3'b001:  sel_n = 3'd1;
      3'b010:  sel_n = 3'd2;
      3'b100:  sel_n = 3'd3;
      3'b101:  sel_n = 3'd4;
      default: sel_n = 3'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    mdr_d      = mdr_q;
    dec_sel_d  = dec_sel_q;
    dec_addr_d = dec_addr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          addr_d     = {req_addr[31:2], 2'b00};
          be_d       = be_n;
          wdata_d    = wdata_n;
          dec_sel_d  = sel_n;
          dec_addr_d = req_addr;
          cnt_d      = '0;
          if (legal) begin
            state_d = ACCESS;
            rd_d    = !req_write;
            wr_d    = req_write;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        // A response on the terminal-count cycle still completes normally.
        if (mem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (!write_q) mdr_d = mem_rdata;
          state_d = DONE;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      mdr_q      <= '0;
      dec_sel_q  <= '0;
      dec_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      mdr_q      <= mdr_d;
      dec_sel_q  <= dec_sel_d;
      dec_addr_q <= dec_addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign mem_address     = addr_q;
  assign mem_read        = rd_q;
  assign mem_write       = wr_q;
  assign mem_byte_enable = be_q;
  assign mem_wdata       = wdata_q;
  assign mdr_out         = mdr_q;
  assign dec_sel         = dec_sel_q;
  assign dec_addr        = dec_addr_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer between the control FSM and the unified data-memory port. It accepts one load or store request at a time and drives the memory handshake with word-aligned addresses, byte enables and lane-shifted store data. It registers the returned word as the MDR value and supplies the MDR decoder with its select code and byte address. Memory latency is unbounded up to a timeout. Every transaction ends with a one-cycle completion pulse.

## Interface
- TIMEOUT_CYCLES, 64: maximum ACCESS-state cycles without mem_resp before abort; range 2..256.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe from control
- req_ready  out  1  high when idle; a request is accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address (rv32i_word)
- req_wdata  in  32  unshifted store data (rv32i_word)
- mem_address  out  32  {addr[31:2], 2'b00}
- mem_read  out  1  read strobe, held until mem_resp
- mem_write  out  1  write strobe, held until mem_resp
- mem_byte_enable  out  4  store lane mask
- mem_wdata  out  32  lane-shifted store data
- mem_resp  in  1  memory completion
- mem_rdata  in  32  read data
- mdr_out  out  32  registered raw read word
- dec_sel  out  3  decoder select: LB 0, LH 1, LW 2, LBU 3, LHU 4
- dec_addr  out  32  full latched byte address, for decoder lane selection
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: timeout, illegal funct3 or misalignment

## Operation
- FSM states: IDLE, ACCESS, DONE. req_ready = (state == IDLE).
- IDLE, on accept:
  - Latch addr, funct3, write flag and store data; clear the wait counter.
  - If the request is legal, go to ACCESS. Otherwise set err_q and go to DONE with no memory strobe.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: anything other than 000, 001, 010.
- ACCESS:
  - mem_read = !write, mem_write = write.
  - The counter increments each cycle.
  - On mem_resp: for a load, load mdr_out <= mem_rdata; go to DONE with err_q = 0.
  - If the counter reaches TIMEOUT_CYCLES-1 without mem_resp: drop both strobes, set err_q, go to DONE. mdr_out is unchanged.
- DONE: done = 1 and err = err_q for exactly one cycle, then return to IDLE.
- Store lanes, with a = addr[1:0]:
  - SB: byte_enable = 4'b0001 << a; wdata = {4{wdata[7:0]}}.
  - SH: byte_enable = 4'b0011 << {a[1], 1'b0}; wdata = {2{wdata[15:0]}}.
  - SW: byte_enable = 4'b1111; wdata unchanged.
- For loads, mem_byte_enable = 4'b1111.
- dec_sel is a registered map of the latched funct3. dec_sel and dec_addr are stable from ACCESS through the next accept.
- mem_resp is ignored outside ACCESS.
- mem_resp arriving on the timeout cycle wins: the transaction completes normally.

## Timing
- Reset values: state IDLE, req_ready 1, mem_read 0, mem_write 0, mem_byte_enable 0, mem_wdata 0, mem_address 0, mdr_out 0, dec_sel 0, dec_addr 0, done 0, err 0.
- rst_n asserted mid-ACCESS drops the strobes asynchronously; no done pulse follows.
- Accept at edge N → strobe high in cycle N+1.
- mem_resp in cycle N+k:
  - mdr_out is valid and done is high in cycle N+k+1.
  - req_ready is high in cycle N+k+2.
- Minimum request-to-request spacing is 3 cycles.
- Rejected request: done/err high in cycle N+1, with no strobe.
- All memory-side outputs are registered; there are no combinational paths from mem_resp to the strobes.

## Configuration
- MISALIGN_TRAP_EN defined: these requests are rejected like an illegal funct3 (err, no strobe):
  - halfword access (LH, LHU, SH) with addr[0] = 1;
  - word access (LW, SW) with addr[1:0] != 0.
- MISALIGN_TRAP_EN undefined: these requests proceed.
  - Halfword at an odd address uses the half selected by addr[1].
  - Word access ignores addr[1:0].
  - err comes only from timeout or illegal funct3.

## Test plan
- LBU at 0x1003, mem_resp after 2 cycles with rdata 0xA1B2C3D4:
  - mem_address 0x1000, mem_read held 2 cycles;
  - mdr_out 0xA1B2C3D4, dec_sel 3, dec_addr 0x1003, done=1, err=0.
- SH of 0x0000BEEF at 0x2002, mem_resp immediate:
  - mem_write for 1 cycle, mem_byte_enable 4'b1100, mem_wdata 0xBEEFBEEF;
  - done 2 cycles after accept.
- Load with no mem_resp, TIMEOUT_CYCLES=4:
  - strobe drops after 4 cycles;
  - done=1 and err=1 in the next cycle; mdr_out retains its prior value.
- LW at 0x3001:
  - with MISALIGN_TRAP_EN: no strobe, done=1 and err=1 one cycle after accept;
  - without it: mem_address 0x3000, normal completion, err=0.
- Load funct3 3'b110: no strobe, done and err the next cycle.
- rst_n pulsed mid-ACCESS: strobes low immediately, all outputs at reset values, no done.
- Back-to-back requests with req_valid held high: the second is accepted only when req_ready is high.
